frame_downscale_gray: RTL

Sits directly downstream of the camera capture stage. Consumes its RGB565 pixel stream with row/col tags, converts each pixel to 8-bit luma and box-averages 2x2 blocks, halving resolution (640x480 -> 320x240). Emits linear framebuffer write requests (address, data, strobe) for the BRAM framebuffer read by the display/thermal overlay path.

---
 rtl/cam_pkg.sv | 37 +++
 rtl/line_buffer_ram.sv | 27 ++
 rtl/frame_downscale_gray.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared camera pixel types, RGB565 field slices and luma helper
package cam_pkg;

    localparam int SRC_W_DEFAULT = 640;
    localparam int SRC_H_DEFAULT = 480;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam logic [7:0] LUMA_KR = 8'd77;
    localparam logic [7:0] LUMA_KG = 8'd150;
    localparam logic [7:0] LUMA_KB = 8'd29;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Coefficients sum to 256, so the weighted sum never exceeds 16 bits.
    function automatic logic [7:0] rgb565_to_luma(input rgb565_t p);
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [15:0] acc;
        r8  = {p.r, p.r[4:2]};
        g8  = {p.g, p.g[5:4]};
        b8  = {p.b, p.b[4:2]};
        acc = 16'(LUMA_KR) * 16'(r8) + 16'(LUMA_KG) * 16'(g8) + 16'(LUMA_KB) * 16'(b8);
        return 8'(acc >> 8);
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - simple dual-port RAM, one write port and one synchronous read port
module line_buffer_ram #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_downscale_gray.sv
// rtl/frame_downscale_gray.sv - RGB565 to luma with 2x2 box downscale into a linear framebuffer
// Optional statistics outputs under FRAME_DOWNSCALE_STATS_EN.
module frame_downscale_gray
    import cam_pkg::*;
#(
    parameter int SRC_W  = SRC_W_DEFAULT,
    parameter int SRC_H  = SRC_H_DEFAULT,
    parameter int ADDR_W = 17
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [15:0]       i_data,
    input  logic [9:0]        i_row,
    input  logic [9:0]        i_col,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_frame_done
`ifdef FRAME_DOWNSCALE_STATS_EN
    ,
    output logic [15:0]       o_frame_count,
    output logic              o_frame_abort
`endif
);

    localparam int HALF_W = SRC_W / 2;
    localparam int IDX_W  = $clog2(HALF_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HALF_W * (SRC_H / 2) - 1);
    localparam logic [9:0] COL_MAX = 10'(SRC_W);
    localparam logic [9:0] ROW_LIM = 10'(SRC_H);

    rgb565_t pix;
    logic    in_range;
    logic    frame_start;
    logic    accept;
    logic    alloc;

    logic              armed;
    logic [ADDR_W-1:0] addr_cnt;

    logic              s1_valid;
    logic [7:0]        s1_y;
    logic              s1_even_col;
    logic              s1_odd_row;
    logic [IDX_W-1:0]  s1_idx;
    logic [ADDR_W-1:0] s1_addr;

    logic [7:0]        held_y;
    logic [8:0]        hsum;
    logic              lb_we;
    logic              lb_re;
    logic [8:0]        lb_rd;

    logic              s2_valid;
    logic [8:0]        s2_hsum;
    logic [ADDR_W-1:0] s2_addr;
    logic [9:0]        total;

    assign pix = '{r: i_data[R_MSB:R_LSB], g: i_data[G_MSB:G_LSB], b: i_data[B_MSB:B_LSB]};

    always_comb begin
        in_range    = (i_col != 10'd0) && (i_col <= COL_MAX) && (i_row < ROW_LIM);
        frame_start = i_valid && (i_row == 10'd0) && (i_col == 10'd1);
        accept      = i_valid && in_range && (armed || frame_start);
        // Output addresses are claimed at input time so in-flight pixels keep theirs across a restart.
        alloc       = accept && i_row[0] && !i_col[0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            armed    <= 1'b0;
            addr_cnt <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (frame_start) begin
                armed    <= 1'b1;
                addr_cnt <= '0;
            end else if (alloc) begin
                if (addr_cnt == LAST_ADDR) begin
                    addr_cnt <= '0;
                    armed    <= 1'b0;
                end else begin
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        s1_y        <= rgb565_to_luma(pix);
        s1_even_col <= !i_col[0];
        s1_odd_row  <= i_row[0];
        s1_idx      <= IDX_W'((i_col >> 1) - 10'd1);
        s1_addr     <= addr_cnt;
    end

    // Horizontal pair: odd column parks its luma, even column completes the sum.
    always_comb begin
        hsum  = {1'b0, held_y} + {1'b0, s1_y};
        lb_we = s1_valid && s1_even_col && !s1_odd_row;
        lb_re = s1_valid && s1_even_col && s1_odd_row;
    end

    line_buffer_ram #(
        .DEPTH (HALF_W),
        .WIDTH (9),
        .AW    (IDX_W)
    ) u_line_buffer (
        .clk   (i_clk),
        .we    (lb_we),
        .waddr (s1_idx),
        .wdata (hsum),
        .re    (lb_re),
        .raddr (s1_idx),
        .rdata (lb_rd)
    );

    always_ff @(posedge i_clk) begin
        if (s1_valid && !s1_even_col) begin
            held_y <= s1_y;
        end
        s2_hsum <= hsum;
        s2_addr <= s1_addr;
    end

    assign total = {1'b0, lb_rd} + {1'b0, s2_hsum};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid     <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            s2_valid     <= lb_re;
            o_wr_en      <= s2_valid;
            if (s2_valid) begin
                o_wr_addr <= s2_addr;
                o_wr_data <= 8'(total >> 2);
            end
            o_frame_done <= o_wr_en && (o_wr_addr == LAST_ADDR);
        end
    end

`ifdef FRAME_DOWNSCALE_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_frame_count <= '0;
            o_frame_abort <= 1'b0;
        end else begin
            if (o_frame_done) begin
                o_frame_count <= o_frame_count + 16'd1;
            end
            o_frame_abort <= frame_start && (addr_cnt != '0);
        end
    end
`endif

endmodule
